// File: rtl/push_crc_seq_pkg.sv
// push_crc_seq_pkg: shared FSM state type and CRC-8 defaults for push_crc_seq
package push_crc_seq_pkg;
    typedef enum logic [1:0] {IDLE, PUSH, CRC} state_t;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
endpackage

// File: rtl/push_crc_seq_crc.sv
// push_crc_seq_crc: one-word CRC-8 update, MSB-first, no reflection, no final XOR
module push_crc_seq_crc #(
    parameter int         DATA_W   = 8,
    parameter logic [7:0] CRC_POLY = 8'h07
) (
    input  logic [7:0]        i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [7:0]        o_crc
);
    always_comb begin
        o_crc = i_crc;
        for (int i = DATA_W - 1; i >= 0; i--)
            o_crc = {o_crc[6:0], 1'b0} ^ ((o_crc[7] ^ i_data[i]) ? CRC_POLY : 8'h00);
    end
endmodule

// File: rtl/push_crc_seq.sv
// push_crc_seq: latches enabled channel words, pushes them in index order, then reports their CRC-8
// Optional stall timeout with err pulse when PUSH_CRC_SEQ_TIMEOUT_EN is defined.
module push_crc_seq
    import push_crc_seq_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] CRC_POLY    = CRC8_POLY,
    parameter logic [7:0] CRC_INIT    = CRC8_INIT,
    parameter int         TIMEOUT_CYC = 16,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     start_ready,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     push_valid,
    input  logic                     push_ready,
    output logic [CH_W-1:0]          push_ch,
    output logic [DATA_W-1:0]        push_data,
    output logic                     crc_valid,
    input  logic                     crc_ready,
    output logic [7:0]               crc_out,
    output logic                     busy,
    output logic                     err
);
    if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("push_crc_seq: parameter out of range");
    end

    state_t                   r_state, w_state_nx;
    logic [NUM_CH-1:0]        r_en;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic [CH_W-1:0]          r_cur, w_first, w_nxt;
    logic                     w_has_nxt, w_go, w_acc, w_tmo_hit;
    logic [7:0]               r_crc, w_crc_nx;
    logic [DATA_W-1:0]        w_word;

    assign w_word = r_data[r_cur*DATA_W +: DATA_W];
    assign w_go   = (r_state == IDLE) && start;
    assign w_acc  = (r_state == PUSH) && push_ready;

    // Descending scan leaves the lowest qualifying index, so skipped channels cost no cycle.
    always_comb begin
        w_first   = '0;
        w_nxt     = '0;
        w_has_nxt = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) w_first = CH_W'(i);
            if (r_en[i] && i > int'(r_cur)) begin
                w_nxt     = CH_W'(i);
                w_has_nxt = 1'b1;
            end
        end
    end

    push_crc_seq_crc #(.DATA_W(DATA_W), .CRC_POLY(CRC_POLY)) u_crc (
        .i_crc (r_crc),
        .i_data(w_word),
        .o_crc (w_crc_nx)
    );

`ifdef PUSH_CRC_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_err, w_stall;
    assign w_stall   = ((r_state == PUSH) && !push_ready) || ((r_state == CRC) && !crc_ready);
    assign w_tmo_hit = w_stall && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign err       = r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (w_stall && !w_tmo_hit) ? r_tmo + 1'b1 : '0;
            r_err <= w_tmo_hit;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_en    <= '0;
            r_data  <= '0;
            r_cur   <= '0;
            r_crc   <= CRC_INIT;
        end else begin
            r_state <= w_state_nx;
            if (w_go) begin
                r_en   <= ch_en;
                r_data <= ch_data;
                r_cur  <= w_first;
                r_crc  <= CRC_INIT;
            end
            if (w_acc) begin
                r_crc <= w_crc_nx;
                r_cur <= w_nxt;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        start_ready = r_state == IDLE;
        busy        = r_state != IDLE;
        push_valid  = r_state == PUSH;
        crc_valid   = r_state == CRC;
        push_ch     = push_valid ? r_cur : '0;
        push_data   = push_valid ? w_word : '0;
        crc_out     = crc_valid ? r_crc : '0;
        case (r_state)
            IDLE:    w_state_nx = start ? (|ch_en ? PUSH : CRC) : IDLE;
            PUSH:    w_state_nx = push_ready ? (w_has_nxt ? PUSH : CRC) : PUSH;
            CRC:     w_state_nx = crc_ready ? IDLE : CRC;
            default: w_state_nx = IDLE;
        endcase
        if (w_tmo_hit) w_state_nx = IDLE;
    end
endmodule

// File: tb/tb_push_crc_seq.sv
// tb_push_crc_seq: directed vectors with hand-computed CRC-8 values against push_crc_seq
module tb_push_crc_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start_ready;
    logic [3:0]  ch_en = '0;
    logic [31:0] ch_data = '0;
    logic        push_valid, push_ready = 1'b0;
    logic [1:0]  push_ch;
    logic [7:0]  push_data;
    logic        crc_valid, crc_ready = 1'b0;
    logic [7:0]  crc_out;
    logic        busy, err;
    int          n_chk = 0, n_err = 0;

    push_crc_seq #(.NUM_CH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .ch_en(ch_en), .ch_data(ch_data), .push_valid(push_valid),
        .push_ready(push_ready), .push_ch(push_ch), .push_data(push_data),
        .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_srdy"}, start_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pv"}, push_valid, 0);
        chk({tag, "_cv"}, crc_valid, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic push_chk(input string tag, input logic [1:0] ch, input logic [7:0] d);
        chk({tag, "_pv"}, push_valid, 1);
        chk({tag, "_ch"}, push_ch, ch);
        chk({tag, "_data"}, push_data, d);
        chk({tag, "_srdy"}, start_ready, 0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_pv", push_valid, 0);
        chk("rst_cv", crc_valid, 0);
        chk("rst_crc", crc_out, 0);
        rst = 1'b0;
        tick;
        idle_chk("reset");
        chk("reset_pdata", push_data, 0);
        chk("reset_pch", push_ch, 0);

        // two channels 01, 02 -> CRC 0x1B; later ch_data change must not matter
        ch_en = 4'b0011; ch_data = 32'h0000_0201; push_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0; ch_data = 32'hDEAD_BEEF; ch_en = 4'b1111;
        push_chk("t1_w0", 2'd0, 8'h01);
        chk("t1_busy", busy, 1);
        tick;
        push_chk("t1_w1", 2'd1, 8'h02);
        tick;
        chk("t1_cv", crc_valid, 1);
        chk("t1_crc", crc_out, 8'h1B);
        chk("t1_pv", push_valid, 0);
        chk("t1_pdata", push_data, 0);
        tick;
        chk("t1_hold", crc_out, 8'h1B);
        crc_ready = 1'b1;
        tick;
        idle_chk("t1_end");
        chk("t1_crc0", crc_out, 0);

        // empty mask goes straight to CRC with the seed
        ch_en = 4'b0000; start = 1'b1;
        tick;
        start = 1'b0;
        chk("t2_pv", push_valid, 0);
        chk("t2_cv", crc_valid, 1);
        chk("t2_crc", crc_out, 8'h00);
        tick;
        idle_chk("t2_end");

        // sparse mask 1010 with stalls and a start while busy; CRC(22,44)=0x5F
        ch_en = 4'b1010; ch_data = 32'h4433_2211; push_ready = 1'b0; crc_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        push_chk("t3_c1", 2'd1, 8'h22);
        tick;
        push_chk("t3_c1_stall", 2'd1, 8'h22);
        start = 1'b1;
        tick;
        push_chk("t3_c1_start", 2'd1, 8'h22);
        start = 1'b0; push_ready = 1'b1;
        tick;
        push_chk("t3_c3", 2'd3, 8'h44);
        push_ready = 1'b0;
        tick;
        push_chk("t3_c3_stall", 2'd3, 8'h44);
        push_ready = 1'b1;
        tick;
        chk("t3_cv", crc_valid, 1);
        chk("t3_crc", crc_out, 8'h5F);
        chk("t3_srdy", start_ready, 0);
        crc_ready = 1'b1;
        tick;
        idle_chk("t3_end");
        tick;
        idle_chk("t3_stay");

        // asynchronous reset mid-push, then a clean single-channel run (ch2=01 -> 0x07)
        ch_en = 4'b1111; ch_data = 32'h0403_0201; push_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        push_chk("t4_pre", 2'd0, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("t4_async_pv", push_valid, 0);
        chk("t4_async_busy", busy, 0);
        tick;
        chk("t4_pv", push_valid, 0);
        chk("t4_cv", crc_valid, 0);
        rst = 1'b0;
        tick;
        idle_chk("t4_idle");
        ch_en = 4'b0100; ch_data = 32'h0001_0000; start = 1'b1;
        tick;
        start = 1'b0;
        push_chk("t4_c2", 2'd2, 8'h01);
        push_ready = 1'b1;
        tick;
        chk("t4_cv2", crc_valid, 1);
        chk("t4_crc", crc_out, 8'h07);
        tick;
        idle_chk("t4_end");

`ifdef PUSH_CRC_SEQ_TIMEOUT_EN
        ch_en = 4'b0001; push_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("t5_wait_err", err, 0);
            chk("t5_wait_pv", push_valid, 1);
        end
        tick;
        chk("t5_err", err, 1);
        chk("t5_srdy", start_ready, 1);
        chk("t5_pv", push_valid, 0);
        tick;
        chk("t5_err_off", err, 0);
        push_ready = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/push_crc_seq.md
PUSH_CRC_SEQ -- requirements
Module: push_crc_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL reset asynchronously on rst high and update on rising clk.
REQ-002 Parameter NUM_CH, default 2: number of push channels, range 1..16.
REQ-003 Parameter DATA_W, default 8: width of each channel word.
REQ-004 Parameter CRC_POLY, default 8'h07: CRC-8 polynomial, normal form, MSB-first.
REQ-005 Parameter CRC_INIT, default 8'h00: CRC seed.
REQ-006 Parameter TIMEOUT_CYC, default 16: stall limit; used only with PUSH_CRC_SEQ_TIMEOUT_EN.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  request a new transaction.
REQ-010 start_ready  out  1  high only in IDLE; a transaction starts on start & start_ready.
REQ-011 ch_en  in  NUM_CH  channel enable mask, sampled at start.
REQ-012 ch_data  in  NUM_CH*DATA_W  channel words (ch0 in LSBs), sampled at start.
REQ-013 push_valid  out  1  word available.
REQ-014 push_ready  in  1  sink accepts word.
REQ-015 push_ch  out  $clog2(NUM_CH) (min 1)  index of current channel.
REQ-016 push_data  out  DATA_W  current word.
REQ-017 crc_valid / crc_ready  out / in  1 / 1  CRC result handshake.
REQ-018 crc_out  out  8  CRC over all accepted words.
REQ-019 busy  out  1  high whenever state is not IDLE.
REQ-020 err  out  1  one-cycle abort pulse; held 0 without the timeout feature.

Function
REQ-021 States: IDLE, PUSH, CRC; no others reachable.
REQ-022 IDLE: on start & start_ready, the block SHALL latch ch_en/ch_data, load crc with CRC_INIT, and go to PUSH at the lowest enabled index; if ch_en==0 it SHALL go directly to CRC.
REQ-023 The first push_valid SHALL be asserted the cycle after start acceptance.
REQ-024 PUSH: push_valid=1, push_ch/push_data SHALL be stable until push_valid & push_ready.
REQ-025 On acceptance: crc <= next_crc(crc, push_data); advance to the next higher enabled index the next cycle (disabled channels skipped, no bubble); after the highest enabled index, go to CRC.
REQ-026 next_crc SHALL process DATA_W bits MSB-first with CRC_POLY, no reflection, no final XOR.
REQ-027 CRC: crc_valid=1, crc_out stable; on crc_valid & crc_ready, go to IDLE; start_ready rises the following cycle.
REQ-028 start while busy SHALL be ignored; ch_en/ch_data changes after acceptance SHALL have no effect.
REQ-029 Outputs outside their valid state: push_data=0, push_ch=0, crc_out=0.

Reset
REQ-030 Reset values: state=IDLE, start_ready=1 (after reset deasserts), push_valid=0, crc_valid=0, busy=0, err=0, crc register=CRC_INIT, timeout counter=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it immediately; no partial CRC is reported.

Configuration
REQ-032 With PUSH_CRC_SEQ_TIMEOUT_EN defined: a counter SHALL increment each PUSH or CRC cycle with valid high and ready low, clear on handshake; on reaching TIMEOUT_CYC it SHALL force IDLE and pulse err for one cycle.
REQ-033 Without the macro: no counter is built, waits are unbounded, err is tied 0.

Structure
REQ-034 Package push_crc_seq_pkg SHALL hold state_t (enum logic[1:0] IDLE, PUSH, CRC) and the CRC-8 default constants.
REQ-035 Combinational sub-module push_crc_seq_crc SHALL compute next_crc(crc, data) parametrised by DATA_W and CRC_POLY.

Verification
REQ-036 Defaults, ch_en=2'b11, ch_data={8'h02,8'h01}, ready=1 -> pushes ch0 0x01, then ch1 0x02; crc_out=0x1B.
REQ-037 ch_en=0 -> no push_valid; crc_valid the cycle after start with crc_out=0x00.
REQ-038 NUM_CH=4, ch_en=4'b1010, push_ready toggling -> only ch1, ch3 pushed; data stable while stalled.
REQ-039 start asserted during PUSH -> ignored; start_ready=0 until after the CRC handshake.
REQ-040 rst pulsed during PUSH -> next cycle push_valid=0, busy=0; new transaction runs correctly.
REQ-041 With timeout macro, push_ready=0 for 16 cycles -> err pulse, state IDLE, start_ready=1.
